// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Brief    : Shared 4-state channel FSM encoding and transition rule.
// Revision : 1.0
// ============================================================================
package fsm_pkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2,
        D = 2'd3
    } state_t;

    localparam int c_STATE_W = 2;

    // Single source of the transition table for the arbiter and the FSM bank.
    function automatic state_t fsm_next(input state_t s, input logic cond);
        state_t w_n;
        case (s)
            A:       w_n = cond ? B : C;
            B:       w_n = cond ? D : C;
            C:       w_n = cond ? A : D;
            default: w_n = cond ? B : C;
        endcase
        return w_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker starting the search at i_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import fsm_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    int                 w_cand;
    logic [IDX_W-1:0]   w_cand_idx;

    // i_ptr is always < N, so one conditional subtraction performs the wrap.
    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        o_vld      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (!o_vld && i_elig[w_cand_idx]) begin
                o_vld = 1'b1;
                o_idx = w_cand_idx;
            end
        end
        if (o_vld) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsm_step_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_step_arbiter
// Brief    : Serialises single-step advances of P_NUM_FSM channel FSMs.
// Revision : 1.0
// ============================================================================
module fsm_step_arbiter
    import fsm_pkg::*;
#(
    parameter int P_NUM_FSM = 8,
    parameter int P_IDX_W   = $clog2(P_NUM_FSM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   I_EN,
    input  logic                   I_FLUSH,
    input  logic [P_NUM_FSM-1:0]   I_REQ,
    input  logic [P_NUM_FSM-1:0]   I_TRANS_COND,
    output logic [P_NUM_FSM-1:0]   O_ACK,
    output logic                   O_GNT_VLD,
    output logic [P_IDX_W-1:0]     O_GNT_IDX,
    output logic [2*P_NUM_FSM-1:0] O_STATE,
    output logic [P_NUM_FSM-1:0]   O_D_HIT
);

    state_t                 r_state [P_NUM_FSM];
    logic [P_IDX_W-1:0]     r_ptr;
    logic [P_NUM_FSM-1:0]   r_ack;
    logic                   r_gnt_vld;
    logic [P_IDX_W-1:0]     r_gnt_idx;
    logic [P_NUM_FSM-1:0]   r_d_hit;

    logic [P_NUM_FSM-1:0]   w_elig;
    logic [P_NUM_FSM-1:0]   w_gnt;
    logic [P_IDX_W-1:0]     w_gnt_idx;
    logic                   w_gnt_vld;
    logic [P_IDX_W-1:0]     w_ptr_nxt;
    state_t                 w_next [P_NUM_FSM];
    logic [P_NUM_FSM-1:0]   w_enter_d;

    // A channel still seeing its own ack is masked so a held request is not re-stepped.
    assign w_elig = I_EN ? (I_REQ & ~r_ack) : '0;

    rr_arbiter #(
        .N     (P_NUM_FSM),
        .IDX_W (P_IDX_W)
    ) u_rr (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_gnt_idx),
        .o_vld  (w_gnt_vld)
    );

    assign w_ptr_nxt = (w_gnt_idx == P_IDX_W'(P_NUM_FSM - 1)) ? '0 : w_gnt_idx + 1'b1;

    generate
        for (genvar g = 0; g < P_NUM_FSM; g++) begin : g_ch
            assign w_next[g]          = fsm_next(r_state[g], I_TRANS_COND[g]);
            assign w_enter_d[g]       = w_gnt[g] && (w_next[g] == D);
            assign O_STATE[2*g +: 2]  = r_state[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || I_FLUSH) begin
            for (int i = 0; i < P_NUM_FSM; i++) begin
                r_state[i] <= A;
            end
            r_ptr     <= '0;
            r_ack     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_idx <= '0;
            r_d_hit   <= '0;
        end else begin
            r_ack     <= w_gnt;
            r_gnt_vld <= w_gnt_vld;
            r_gnt_idx <= w_gnt_vld ? w_gnt_idx : '0;
            r_d_hit   <= w_enter_d;
            if (w_gnt_vld) begin
                r_ptr <= w_ptr_nxt;
            end
            for (int i = 0; i < P_NUM_FSM; i++) begin
                if (w_gnt[i]) begin
                    r_state[i] <= w_next[i];
                end
            end
        end
    end

    assign O_ACK     = r_ack;
    assign O_GNT_VLD = r_gnt_vld;
    assign O_GNT_IDX = r_gnt_idx;
    assign O_D_HIT   = r_d_hit;

`ifndef SYNTHESIS
    a_ack_onehot : assert property (@(posedge clk) $onehot0(O_ACK));
    a_vld_vs_ack : assert property (@(posedge clk) O_GNT_VLD == (|O_ACK));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_step_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_step_arbiter
// Brief    : Directed and randomized checks of fsm_step_arbiter against a model.
// Revision : 1.0
// ============================================================================
module tb_fsm_step_arbiter;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           I_EN;
    logic           I_FLUSH;
    logic [N-1:0]   I_REQ;
    logic [N-1:0]   I_TRANS_COND;
    logic [N-1:0]   O_ACK;
    logic           O_GNT_VLD;
    logic [2:0]     O_GNT_IDX;
    logic [2*N-1:0] O_STATE;
    logic [N-1:0]   O_D_HIT;

    always #5 clk = ~clk;

    fsm_step_arbiter #(.P_NUM_FSM(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .I_EN         (I_EN),
        .I_FLUSH      (I_FLUSH),
        .I_REQ        (I_REQ),
        .I_TRANS_COND (I_TRANS_COND),
        .O_ACK        (O_ACK),
        .O_GNT_VLD    (O_GNT_VLD),
        .O_GNT_IDX    (O_GNT_IDX),
        .O_STATE      (O_STATE),
        .O_D_HIT      (O_D_HIT)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: next-state table indexed [state][cond].
    int           TBL [4][2] = '{'{2, 1}, '{2, 3}, '{3, 0}, '{2, 1}};
    int           m_state [N];
    int           m_ptr  = 0;
    logic [N-1:0] m_ack  = '0;
    logic [N-1:0] m_dhit = '0;
    logic         m_vld  = 1'b0;
    int           m_idx  = 0;

    function automatic void model_step();
        logic [N-1:0] nack = '0;
        logic [N-1:0] ndh  = '0;
        logic         nvld = 1'b0;
        int           nidx = 0;
        if (rst || I_FLUSH) begin
            for (int i = 0; i < N; i++) m_state[i] = 0;
            m_ptr = 0;
        end else if (I_EN) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (!nvld && I_REQ[c] && !m_ack[c]) begin
                    nvld = 1'b1;
                    nidx = c;
                end
            end
            if (nvld) begin
                m_state[nidx] = TBL[m_state[nidx]][int'(I_TRANS_COND[nidx])];
                nack[nidx] = 1'b1;
                ndh[nidx]  = (m_state[nidx] == 3);
                m_ptr      = (nidx + 1) % N;
            end
        end
        m_ack  = nack;
        m_vld  = nvld;
        m_idx  = nidx;
        m_dhit = ndh;
    endfunction

    function automatic logic [2*N-1:0] m_packed();
        logic [2*N-1:0] p = '0;
        for (int i = 0; i < N; i++) p[2*i +: 2] = 2'(m_state[i]);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; I_EN = 1'b1; I_FLUSH = 1'b0; I_REQ = '0; I_TRANS_COND = '0;
        tick(); tick();
        n_checks++;
        if ({O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT} !== '0)
            $display("FAIL reset_values: state=%h ack=%h vld=%b idx=%0d dhit=%h, required all 0",
                     O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT);
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            I_TRANS_COND = 8'($urandom);
            tick();
            n_checks++;
            if ({O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT} !== '0)
                $display("FAIL idle cycle %0d: state=%h ack=%h vld=%b idx=%0d dhit=%h, required all 0",
                         c, O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT);
            else n_pass++;
        end
    endtask

    task automatic test_single_walk();
        int conds [4] = '{1, 1, 0, 1};
        int exp_s [4] = '{1, 3, 2, 0};
        int waited;
        I_REQ = 8'h08;
        for (int j = 0; j < 4; j++) begin
            I_TRANS_COND = (8'($urandom) & 8'hF7) | 8'(conds[j] << 3);
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!O_ACK[3] && waited < 10);
            n_checks++;
            if (!O_ACK[3]) $display("FAIL walk_ack step %0d: no ack within %0d cycles", j, waited);
            else n_pass++;
            n_checks++;
            if (int'(O_STATE[7:6]) !== exp_s[j])
                $display("FAIL walk_state step %0d: got %0d, required %0d", j, O_STATE[7:6], exp_s[j]);
            else n_pass++;
            n_checks++;
            if (O_D_HIT !== ((j == 1) ? 8'h08 : 8'h00))
                $display("FAIL walk_dhit step %0d: got %h, required %h", j, O_D_HIT, (j == 1) ? 8'h08 : 8'h00);
            else n_pass++;
            n_checks++;
            if (waited !== ((j == 0) ? 1 : 2))
                $display("FAIL walk_spacing step %0d: got %0d cycles, required %0d", j, waited, (j == 0) ? 1 : 2);
            else n_pass++;
        end
        I_REQ = '0;
        tick();
    endtask

    task automatic test_round_robin();
        I_FLUSH = 1'b1; tick(); I_FLUSH = 1'b0;
        I_REQ = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            I_TRANS_COND = 8'($urandom);
            tick();
            n_checks++;
            if (!O_GNT_VLD || int'(O_GNT_IDX) != k % N || O_ACK !== 8'(1 << (k % N)))
                $display("FAIL rr_order cycle %0d: vld=%b idx=%0d ack=%h, required vld=1 idx=%0d ack=%h",
                         k, O_GNT_VLD, O_GNT_IDX, O_ACK, k % N, 8'(1 << (k % N)));
            else n_pass++;
        end
        n_checks++;
        if (O_STATE !== m_packed()) $display("FAIL rr_states: got %h, required %h", O_STATE, m_packed());
        else n_pass++;
        I_REQ = '0;
        tick();
    endtask

    task automatic test_ptr_wrap();
        int exp_idx [3] = '{5, 0, 2};
        logic [N-1:0] next_req [3] = '{8'b0000_0101, 8'b0000_0100, 8'b0001_0010};
        I_FLUSH = 1'b1; tick(); I_FLUSH = 1'b0;
        I_REQ = 8'b0010_0000;
        for (int k = 0; k < 3; k++) begin
            I_TRANS_COND = 8'($urandom);
            tick();
            n_checks++;
            if (!O_GNT_VLD || int'(O_GNT_IDX) != exp_idx[k])
                $display("FAIL wrap_order step %0d: vld=%b idx=%0d, required idx %0d", k, O_GNT_VLD, O_GNT_IDX, exp_idx[k]);
            else n_pass++;
            I_REQ = next_req[k];
        end
        tick();
        n_checks++;
        if (!O_GNT_VLD || O_GNT_IDX !== 3'd4)
            $display("FAIL wrap_ptr: vld=%b idx=%0d, required idx 4 (ptr at 3)", O_GNT_VLD, O_GNT_IDX);
        else n_pass++;
        I_REQ = '0;
        tick();
    endtask

    task automatic test_enable();
        I_EN = 1'b0;
        I_REQ = 8'h01;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (O_ACK !== '0 || O_GNT_VLD !== 1'b0 || O_D_HIT !== '0)
                $display("FAIL en_gate cycle %0d: ack=%h vld=%b dhit=%h, required 0", k, O_ACK, O_GNT_VLD, O_D_HIT);
            else n_pass++;
        end
        I_EN = 1'b1;
        tick();
        n_checks++;
        if (O_ACK !== 8'h01 || !O_GNT_VLD || O_GNT_IDX !== 3'd0)
            $display("FAIL en_resume: ack=%h vld=%b idx=%0d, required ack=01 vld=1 idx=0", O_ACK, O_GNT_VLD, O_GNT_IDX);
        else n_pass++;
        I_REQ = '0;
        tick();
    endtask

    task automatic test_flush();
        logic [N-1:0] exp_dh [4] = '{8'h00, 8'h00, 8'h02, 8'h20};
        I_FLUSH = 1'b1; tick(); I_FLUSH = 1'b0;
        I_REQ = 8'h22;
        I_TRANS_COND = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (O_D_HIT !== exp_dh[k]) $display("FAIL flush_setup_dhit step %0d: got %h, required %h", k, O_D_HIT, exp_dh[k]);
            else n_pass++;
        end
        n_checks++;
        if (O_STATE[3:2] !== 2'd3 || O_STATE[11:10] !== 2'd3)
            $display("FAIL flush_setup_state: got %h, required ch1 and ch5 in D", O_STATE);
        else n_pass++;
        I_REQ = 8'hFF;
        I_TRANS_COND = 8'($urandom);
        I_FLUSH = 1'b1;
        tick();
        I_FLUSH = 1'b0;
        n_checks++;
        if ({O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT} !== '0)
            $display("FAIL flush_clear: state=%h ack=%h vld=%b idx=%0d dhit=%h, required all 0",
                     O_STATE, O_ACK, O_GNT_VLD, O_GNT_IDX, O_D_HIT);
        else n_pass++;
        tick();
        n_checks++;
        if (!O_GNT_VLD || O_GNT_IDX !== 3'd0 || O_ACK !== 8'h01)
            $display("FAIL flush_resume: vld=%b idx=%0d ack=%h, required vld=1 idx=0 ack=01", O_GNT_VLD, O_GNT_IDX, O_ACK);
        else n_pass++;
        I_REQ = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] req  = '0;
        logic [N-1:0] cond = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (m_ack[i] || !req[i]) begin
                    req[i]  = ($urandom_range(0, 2) == 0);
                    cond[i] = 1'($urandom);
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            I_REQ        = req;
            I_TRANS_COND = cond;
            I_EN         = ($urandom_range(0, 7) != 0);
            I_FLUSH      = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (O_STATE !== m_packed()) $display("FAIL rnd_state cycle %0d: got %h, required %h", cyc, O_STATE, m_packed());
            else n_pass++;
            n_checks++;
            if (O_ACK !== m_ack || O_GNT_VLD !== m_vld)
                $display("FAIL rnd_ack cycle %0d: ack=%h vld=%b, required ack=%h vld=%b", cyc, O_ACK, O_GNT_VLD, m_ack, m_vld);
            else n_pass++;
            if (m_vld) begin
                n_checks++;
                if (int'(O_GNT_IDX) !== m_idx) $display("FAIL rnd_idx cycle %0d: got %0d, required %0d", cyc, O_GNT_IDX, m_idx);
                else n_pass++;
            end
            n_checks++;
            if (O_D_HIT !== m_dhit) $display("FAIL rnd_dhit cycle %0d: got %h, required %h", cyc, O_D_HIT, m_dhit);
            else n_pass++;
        end
        rst = 1'b0; I_FLUSH = 1'b0; I_EN = 1'b1; I_REQ = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_state[i] = 0;
        test_reset();
        test_single_walk();
        test_round_robin();
        test_ptr_wrap();
        test_enable();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fsm_step_arbiter.md
# fsm_step_arbiter

Round-robin scheduler that shares a single per-cycle "step" slot among `P_NUM_FSM` requesters, each owning one 4-state control FSM (states A/B/C/D). It sits in front of the parameterised FSM bank and serialises its advances: at most one FSM moves per cycle, and that FSM is the one whose request was granted. The block holds the authoritative state of every channel, acknowledges each step with a one-cycle pulse, and flags entries into state D.

## Interface
Parameters:
- `P_NUM_FSM`, default 8: number of channels/FSMs. Legal range is 2..64.
- `P_IDX_W`, default `$clog2(P_NUM_FSM)`: width of the grant index. Derived; not to be overridden.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `I_EN`, input, 1: global enable. When low, no grants are issued and all states hold.
- `I_FLUSH`, input, 1: synchronous soft clear of all FSMs and the priority pointer.
- `I_REQ`, input, `P_NUM_FSM`: per-channel step request. Level-held until acked.
- `I_TRANS_COND`, input, `P_NUM_FSM`: per-channel transition condition. Sampled with the grant.
- `O_ACK`, output, `P_NUM_FSM`: one-hot, single-cycle acknowledge of a completed step.
- `O_GNT_VLD`, output, 1: a step was performed at the last edge.
- `O_GNT_IDX`, output, `P_IDX_W`: index of the stepped channel. Valid only with `O_GNT_VLD`.
- `O_STATE`, output, `2*P_NUM_FSM`: packed current state of each channel. Channel i occupies bits `[2i+1:2i]`.
- `O_D_HIT`, output, `P_NUM_FSM`: one-cycle pulse when channel i has just entered D.

## Operation
- **State encoding:** A=0, B=1, C=2, D=3.
- **Next-state rule for the granted channel:**
  - A: cond → B, else → C.
  - B: cond → D, else → C.
  - C: cond → A, else → D.
  - D: cond → B, else → C.
- **Eligibility:** channel i is eligible when `I_REQ[i]=1` and `O_ACK[i]=0`. The second term masks the cycle in which the requester is still seeing its own ack.
- **Arbitration:**
  - Search the eligible channels starting at pointer `ptr`, moving upward and wrapping from `P_NUM_FSM-1` to 0.
  - The first hit is granted.
  - After a grant to channel i, `ptr` becomes `(i+1) mod P_NUM_FSM`.
  - `ptr` is unchanged when nothing is granted.
- **At the edge of a grant:**
  - The granted channel's state updates using `I_TRANS_COND[i]` as sampled at that edge.
  - `O_ACK[i]`, `O_GNT_VLD` and `O_GNT_IDX` assert for the following cycle.
  - `O_D_HIT[i]` is set if the new state is D. This includes D→D, which does not occur under the table but is covered by the same rule.
- **Ungranted channels:** state holds.
- **Requester contract:**
  - Hold `I_REQ` and `I_TRANS_COND` stable until `O_ACK` is seen.
  - Deassert `I_REQ`, or re-present it for a new step, in the cycle after the ack.
  - A request dropped before its ack is simply never serviced. This is legal.
- **`I_EN=0`:** no grant; `ptr` and states hold. `O_ACK`, `O_GNT_VLD` and `O_D_HIT` are 0 in the next cycle.
- **`I_FLUSH=1`:** overrides `I_EN` and any grant.
  - Next cycle: all states = A, `ptr` = 0, and `O_ACK`, `O_GNT_VLD`, `O_GNT_IDX` and `O_D_HIT` are all 0.
  - Requests pending at the flush remain pending and arbitrate normally afterwards.
- **Reset:** has the same effect as flush and overrides everything.
  - Reset values: `O_STATE` = all A (0), `O_ACK` = 0, `O_GNT_VLD` = 0, `O_GNT_IDX` = 0, `O_D_HIT` = 0, `ptr` = 0.
  - Reset asserted mid-step discards that step; the requester is never acked for it.

## Timing
- Request to ack: 1 cycle minimum. Requests sampled at edge t are acked during cycle t+1.
- Worst-case wait for a continuously held request is `P_NUM_FSM` grants. This is the starvation-freedom bound.
- Throughput: one step per cycle overall.
  - A single channel can step at most every 2 cycles because of the ack mask.
  - With two or more active channels, steps occur back-to-back every cycle.
- `O_STATE` is registered and reflects the step in the same cycle as `O_ACK`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `fsm_pkg`:**
  - `state_t` enum `logic [1:0] {A,B,C,D}`.
  - Function `fsm_next(state_t s, logic cond)` implementing the table.
  - This package is shared with the FSM bank, so both use the identical transition rule.
- **Sub-module `rr_arbiter`:**
  - Parameterised by N.
  - Inputs: eligible vector and `ptr`.
  - Outputs: one-hot grant, grant index and valid. Purely combinational.
  - The pointer register lives in `fsm_step_arbiter`.
- **Top level:** holds the state array, `ptr`, output registers, and flush/enable/reset priority.

## Test plan
- **Reset/idle:** after `rst` with `I_REQ=0`, all `O_STATE`=0 and all strobes are 0 for 10 cycles. Toggling `I_TRANS_COND` changes nothing.
- **Single channel walk:** with N=8, channel 3 steps with cond sequence 1,1,0,1.
  - States go B, D, C, A.
  - `O_D_HIT[3]` pulses once, on the second ack.
  - Acks are at least 2 cycles apart.
- **Round-robin fairness:** hold `I_REQ=8'hFF`.
  - Grant indices are 0,1,...,7,0 on consecutive cycles, with no gaps.
  - Each channel is acked once per 8 cycles.
- **Pointer wrap:** with `ptr`=6, drive `I_REQ=8'b0000_0101`.
  - Grant order is 0 then 2.
  - `ptr` ends at 3.
- **Enable gating:** drive `I_EN=0` for 4 cycles with `I_REQ=8'h01`.
  - No ack is issued.
  - When enable rises, the ack arrives 1 cycle later.
- **Flush mid-traffic:** channels 1 and 5 are in D and `I_REQ=8'hFF` when `I_FLUSH` pulses.
  - Next cycle: all states are A, no ack, and `ptr`=0.
  - Grants then resume at index 0.
